// File: rtl/simd_pkg.sv
// simd_pkg: types and constants shared by the SIMD BRAM loader.
//   loader_target_e : destination BRAM selected by a loader command
//   loader_state_e  : loader FSM states
//   INS_WORDS       : stream words per instruction row at the default widths
package simd_pkg;

   typedef enum logic [1:0] {
      TGT_A    = 2'd0,
      TGT_B    = 2'd1,
      TGT_INS  = 2'd2,
      TGT_RSVD = 2'd3
   } loader_target_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } loader_state_e;

   localparam int LDR_DATA_WIDTH = 32;
   localparam int LDR_INS_WIDTH  = 64;
   localparam int INS_WORDS      = LDR_INS_WIDTH / LDR_DATA_WIDTH;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/row_packer.sv
// row_packer: packs stream words into a row, lane 0 in the least significant bits.
//   in_valid/in_data : accepted stream word
//   words_per_row    : lanes that make up a full row for the current command
//   flush            : qualifies in_valid; close the row after this word, zero-padding the rest
//   row_valid        : row_data holds a row to be written this cycle
//   row_full         : the row closed because its last lane was filled
//   row_data         : assembled row including the word being accepted
module row_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WORDS  = 4,
   parameter int CW         = $clog2(MAX_WORDS + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic [DATA_WIDTH-1:0]           in_data,
   input  logic [CW-1:0]                   words_per_row,
   input  logic                            flush,
   output logic                            row_valid,
   output logic                            row_full,
   output logic [MAX_WORDS*DATA_WIDTH-1:0] row_data
);

   logic [CW-1:0]                        lane_q, lane_d;
   logic [MAX_WORDS-1:0][DATA_WIDTH-1:0] lanes_q, lanes_d, merged;

   always_comb begin
      for (int i = 0; i < MAX_WORDS; i++) begin
         merged[i] = (CW'(i) == lane_q) ? in_data : lanes_q[i];
      end
      row_full  = in_valid && (lane_q == words_per_row - CW'(1));
      row_valid = row_full || (in_valid && flush);
      row_data  = merged;
      lane_d    = lane_q;
      lanes_d   = lanes_q;
      // Clearing the assembly register on every emitted row is what zero-pads a flushed row.
      if (row_valid) begin
         lane_d  = '0;
         lanes_d = '0;
      end else if (in_valid) begin
         lane_d  = lane_q + CW'(1);
         lanes_d = merged;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q  <= '0;
         lanes_q <= '0;
      end else begin
         lane_q  <= lane_d;
         lanes_q <= lanes_d;
      end
   end

endmodule

// File: rtl/bram_loader.sv
// bram_loader: fills operand BRAMs A/B and the instruction BRAM from a word stream.
//   cmd_*      : command handshake (target, first row, row count); accepted only in IDLE
//   s_*        : word stream, one word per cycle while loading; s_last ends the command
//   bram_*_wr_*: registered row-wide write ports, one pulse per completed row
//   done/err   : one-cycle end-of-command pulse, err flags reserved target or bad s_last
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready=1
// ST_LOAD  | accepting stream words, s_ready=1
// ST_FLUSH | final/partial row in the write stage, stream stalled
// ST_DONE  | done (and err if flagged) pulse
module bram_loader
   import simd_pkg::*;
#(
   parameter int PE_COUNT       = 4,
   parameter int DATA_WIDTH     = LDR_DATA_WIDTH,
   parameter int ADDR_WIDTH     = 10,
   parameter int INS_ADDR_WIDTH = 11,
   parameter int INS_WIDTH      = INS_WORDS * LDR_DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_target,
   input  logic [INS_ADDR_WIDTH-1:0]      cmd_base,
   input  logic [INS_ADDR_WIDTH:0]        cmd_len,
   input  logic [DATA_WIDTH-1:0]          s_data,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic                           s_last,
   output logic                           bram_a_wr_en,
   output logic [ADDR_WIDTH-1:0]          bram_a_wr_addr,
   output logic [PE_COUNT*DATA_WIDTH-1:0] bram_a_wr_data,
   output logic                           bram_b_wr_en,
   output logic [ADDR_WIDTH-1:0]          bram_b_wr_addr,
   output logic [PE_COUNT*DATA_WIDTH-1:0] bram_b_wr_data,
   output logic                           bram_ins_wr_en,
   output logic [INS_ADDR_WIDTH-1:0]      bram_ins_wr_addr,
   output logic [INS_WIDTH-1:0]           bram_ins_wr_data,
   output logic                           done,
   output logic                           err
);

   localparam int INS_ROW_WORDS = INS_WIDTH / DATA_WIDTH;
   localparam int MAX_WORDS     = max2(PE_COUNT, INS_ROW_WORDS);
   localparam int CW            = $clog2(MAX_WORDS + 1);
   localparam int LEN_W         = INS_ADDR_WIDTH + 1;
   localparam int ROW_W         = MAX_WORDS * DATA_WIDTH;

   loader_state_e             state_q, state_d;
   loader_target_e            target_q, target_d;
   logic [INS_ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
   logic [LEN_W-1:0]          rows_q, rows_d;
   logic                      err_flag_q, err_flag_d;
   logic                      cmd_ready_q, cmd_ready_d;
   logic                      s_ready_q, s_ready_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic                      wr_a_en_q, wr_a_en_d;
   logic                      wr_b_en_q, wr_b_en_d;
   logic                      wr_ins_en_q, wr_ins_en_d;
   logic [INS_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [ROW_W-1:0]          wr_data_q, wr_data_d;

   logic                      accept;
   logic                      last_word;
   logic                      pk_flush;
   logic                      pk_row_valid;
   logic                      pk_row_full;
   logic [ROW_W-1:0]          pk_row_data;
   logic [CW-1:0]             words_per_row;

   assign accept        = s_ready_q && s_valid;
   assign words_per_row = (target_q == TGT_INS) ? CW'(INS_ROW_WORDS) : CW'(PE_COUNT);
   assign last_word     = pk_row_full && (rows_q == LEN_W'(1));
   // s_last anywhere but the final word cuts the command short.
   assign pk_flush      = s_last && !last_word;

   row_packer #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_WORDS  (MAX_WORDS),
      .CW         (CW)
   ) u_row_packer (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (accept),
      .in_data       (s_data),
      .words_per_row (words_per_row),
      .flush         (pk_flush),
      .row_valid     (pk_row_valid),
      .row_full      (pk_row_full),
      .row_data      (pk_row_data)
   );

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      row_addr_d  = row_addr_q;
      rows_d      = rows_q;
      err_flag_d  = err_flag_q;
      wr_a_en_d   = 1'b0;
      wr_b_en_d   = 1'b0;
      wr_ins_en_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               target_d   = loader_target_e'(cmd_target);
               row_addr_d = cmd_base;
               rows_d     = cmd_len;
               err_flag_d = (cmd_target == TGT_RSVD);
               state_d    = (cmd_len == '0 || cmd_target == TGT_RSVD) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (pk_row_valid) begin
               wr_a_en_d   = (target_q == TGT_A);
               wr_b_en_d   = (target_q == TGT_B);
               wr_ins_en_d = (target_q == TGT_INS);
               wr_addr_d   = row_addr_q;
               wr_data_d   = pk_row_data;
            end
            if (pk_row_full) begin
               row_addr_d = row_addr_q + 1'b1;
               rows_d     = rows_q - LEN_W'(1);
            end
            // The last row needs one cycle in the write stage before done, hence FLUSH.
            if (accept && (last_word || s_last)) begin
               state_d    = ST_FLUSH;
               err_flag_d = !(last_word && s_last);
            end
         end
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
      s_ready_d   = (state_d == ST_LOAD);
      done_d      = (state_d == ST_DONE);
      err_d       = (state_d == ST_DONE) && err_flag_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         target_q    <= TGT_A;
         row_addr_q  <= '0;
         rows_q      <= '0;
         err_flag_q  <= 1'b0;
         cmd_ready_q <= 1'b0;
         s_ready_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wr_a_en_q   <= 1'b0;
         wr_b_en_q   <= 1'b0;
         wr_ins_en_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         row_addr_q  <= row_addr_d;
         rows_q      <= rows_d;
         err_flag_q  <= err_flag_d;
         cmd_ready_q <= cmd_ready_d;
         s_ready_q   <= s_ready_d;
         done_q      <= done_d;
         err_q       <= err_d;
         wr_a_en_q   <= wr_a_en_d;
         wr_b_en_q   <= wr_b_en_d;
         wr_ins_en_q <= wr_ins_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign cmd_ready        = cmd_ready_q;
   assign s_ready          = s_ready_q;
   assign done             = done_q;
   assign err              = err_q;
   assign bram_a_wr_en     = wr_a_en_q;
   assign bram_a_wr_addr   = wr_addr_q[ADDR_WIDTH-1:0];
   assign bram_a_wr_data   = wr_data_q[PE_COUNT*DATA_WIDTH-1:0];
   assign bram_b_wr_en     = wr_b_en_q;
   assign bram_b_wr_addr   = wr_addr_q[ADDR_WIDTH-1:0];
   assign bram_b_wr_data   = wr_data_q[PE_COUNT*DATA_WIDTH-1:0];
   assign bram_ins_wr_en   = wr_ins_en_q;
   assign bram_ins_wr_addr = wr_addr_q;
   assign bram_ins_wr_data = wr_data_q[INS_WIDTH-1:0];

endmodule
